sram_wr_arbiter: RTL and testbench

- Packet-granular round-robin scheduler that shares the single SRAM write channel of the buffer controller between NUM_PORTS write ingress ports.
- A grant is held from sop to eop, so packets are never interleaved.
- The winning port's beats pass through a one-stage registered pipeline, tagged with the source port id.
- Sits between the per-port ingress interfaces and the SRAM write/link-list manager.

---
 rtl/sram_wr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sram_wr_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one SRAM write channel between ingress ports.
// Optional: define SRAM_WR_ARB_LEN_CHECK_EN for the MAX_LEN overrun check and DRAIN state.
module sram_wr_arbiter #(
   parameter  int NUM_PORTS = 2,
   parameter  int DATA_W    = 8,
   parameter  int MAX_LEN   = 64,
   localparam int PORT_W    = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                        i_clock,
   input  logic                        i_reset_n,
   input  logic [NUM_PORTS-1:0]        i_in_valid,
   input  logic [NUM_PORTS*DATA_W-1:0] i_in_data,
   input  logic [NUM_PORTS-1:0]        i_in_sop,
   input  logic [NUM_PORTS-1:0]        i_in_eop,
   output logic [NUM_PORTS-1:0]        o_in_ready,
   output logic                        o_out_valid,
   output logic [DATA_W-1:0]           o_out_data,
   output logic                        o_out_sop,
   output logic                        o_out_eop,
   output logic [PORT_W-1:0]           o_out_port,
   input  logic                        i_out_ready,
   output logic                        o_busy,
   output logic                        o_drop_pulse,
   output logic                        o_proto_err,
   output logic                        o_len_err
);

`ifdef SRAM_WR_ARB_LEN_CHECK_EN
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_BUSY} state_t;
`endif

   if (NUM_PORTS < 2 || NUM_PORTS > 16 || MAX_LEN < 1) begin : g_param_chk
      $error("sram_wr_arbiter: unsupported parameter set");
   end

   state_t              r_state;
   logic [PORT_W-1:0]   r_grant;
   logic [PORT_W-1:0]   r_rr_ptr;
   logic                r_first;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_sop;
   logic                r_out_eop;
   logic [PORT_W-1:0]   r_out_port;
   logic                r_drop;
   logic                r_proto;

   logic [NUM_PORTS-1:0] w_req;
   logic                 w_found;
   logic [PORT_W-1:0]    w_pick;
   logic [PORT_W-1:0]    w_next;
   logic                 w_pipe_free;
   logic                 w_acc;
   logic                 w_sop;
   logic                 w_eop;
   logic                 w_len_hit;
   logic [DATA_W-1:0]    w_data;

   assign w_req       = i_in_valid & i_in_sop;
   assign w_pipe_free = !r_out_valid || i_out_ready;
   assign w_data      = i_in_data[r_grant*DATA_W +: DATA_W];
   assign w_sop       = i_in_sop[r_grant];
   assign w_eop       = i_in_eop[r_grant];
   assign w_acc       = (r_state == S_BUSY) && i_in_valid[r_grant] && w_pipe_free;

   // First requester at or above rr_ptr, wrapping around.
   always_comb begin
      int v;
      v       = 0;
      w_found = 1'b0;
      w_pick  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         v = int'(r_rr_ptr) + i;
         if (v >= NUM_PORTS) v = v - NUM_PORTS;
         if (!w_found && w_req[v]) begin
            w_found = 1'b1;
            w_pick  = PORT_W'(v);
         end
      end
   end

   always_comb begin
      w_next = r_grant + 1'b1;
      if (int'(r_grant) == NUM_PORTS - 1) w_next = '0;
   end

   always_comb begin
      o_in_ready = '0;
      case (r_state)
         S_IDLE:  o_in_ready = i_in_valid & ~i_in_sop;
         S_BUSY:  o_in_ready[r_grant] = w_pipe_free;
`ifdef SRAM_WR_ARB_LEN_CHECK_EN
         S_DRAIN: o_in_ready[r_grant] = 1'b1;
`endif
         default: o_in_ready = '0;
      endcase
   end

`ifdef SRAM_WR_ARB_LEN_CHECK_EN
   localparam int CNT_W = $clog2(MAX_LEN + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             r_len;
   // The MAX_LEN-th beat without eop closes the packet on the output side.
   assign w_len_hit = (r_cnt == CNT_W'(MAX_LEN - 1)) && !w_eop;
   assign o_len_err = r_len;
`else
   assign w_len_hit = 1'b0;
   assign o_len_err = 1'b0;
`endif

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= S_IDLE;
         r_grant     <= '0;
         r_rr_ptr    <= '0;
         r_first     <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
         r_out_port  <= '0;
         r_drop      <= 1'b0;
         r_proto     <= 1'b0;
`ifdef SRAM_WR_ARB_LEN_CHECK_EN
         r_cnt       <= '0;
         r_len       <= 1'b0;
`endif
      end else begin
         r_drop  <= 1'b0;
         r_proto <= 1'b0;
`ifdef SRAM_WR_ARB_LEN_CHECK_EN
         r_len   <= 1'b0;
`endif
         if (w_pipe_free) r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_drop <= |(i_in_valid & ~i_in_sop);
               if (w_found) begin
                  r_grant <= w_pick;
                  r_first <= 1'b1;
                  r_state <= S_BUSY;
`ifdef SRAM_WR_ARB_LEN_CHECK_EN
                  r_cnt   <= '0;
`endif
               end
            end
            S_BUSY: begin
               if (w_acc) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_data;
                  r_out_sop   <= w_sop;
                  r_out_eop   <= w_eop | w_len_hit;
                  r_out_port  <= r_grant;
                  r_first     <= 1'b0;
                  r_proto     <= w_sop & ~r_first;
`ifdef SRAM_WR_ARB_LEN_CHECK_EN
                  r_cnt       <= r_cnt + 1'b1;
                  r_len       <= w_len_hit;
                  if (w_len_hit) r_state <= S_DRAIN;
`endif
                  if (w_eop) begin
                     r_state  <= S_IDLE;
                     r_rr_ptr <= w_next;
                  end
               end
            end
`ifdef SRAM_WR_ARB_LEN_CHECK_EN
            S_DRAIN: begin
               if (i_in_valid[r_grant] && w_eop) begin
                  r_state  <= S_IDLE;
                  r_rr_ptr <= w_next;
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_out_valid  = r_out_valid;
   assign o_out_data   = r_out_data;
   assign o_out_sop    = r_out_sop;
   assign o_out_eop    = r_out_eop;
   assign o_out_port   = r_out_port;
   assign o_busy       = (r_state != S_IDLE);
   assign o_drop_pulse = r_drop;
   assign o_proto_err  = r_proto;

endmodule

// File: tb/tb_sram_wr_arbiter.sv
// Bench for sram_wr_arbiter: directed scenarios plus randomized packets checked against a
// packet-level round-robin model. Honours SRAM_WR_ARB_LEN_CHECK_EN (MAX_LEN=4 when defined).
module tb_sram_wr_arbiter;
   localparam int NP = 3;
   localparam int DW = 8;
   localparam int PW = 2;
`ifdef SRAM_WR_ARB_LEN_CHECK_EN
   localparam int ML     = 4;
   localparam bit LEN_ON = 1'b1;
`else
   localparam int ML     = 64;
   localparam bit LEN_ON = 1'b0;
`endif

   typedef struct packed {logic [DW-1:0] d; logic sop; logic eop;} beat_t;
   typedef struct packed {logic [DW-1:0] d; logic sop; logic eop; logic [PW-1:0] port;} obeat_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NP-1:0]    in_valid = '0;
   logic [NP*DW-1:0] in_data = '0;
   logic [NP-1:0]    in_sop = '0;
   logic [NP-1:0]    in_eop = '0;
   logic [NP-1:0]    o_in_ready;
   logic             o_out_valid;
   logic [DW-1:0]    o_out_data;
   logic             o_out_sop;
   logic             o_out_eop;
   logic [PW-1:0]    o_out_port;
   logic             out_ready = 1'b1;
   logic             o_busy;
   logic             o_drop_pulse;
   logic             o_proto_err;
   logic             o_len_err;

   sram_wr_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .MAX_LEN(ML)) dut (
      .i_clock(clk), .i_reset_n(rst_n),
      .i_in_valid(in_valid), .i_in_data(in_data), .i_in_sop(in_sop), .i_in_eop(in_eop),
      .o_in_ready(o_in_ready),
      .o_out_valid(o_out_valid), .o_out_data(o_out_data), .o_out_sop(o_out_sop),
      .o_out_eop(o_out_eop), .o_out_port(o_out_port), .i_out_ready(out_ready),
      .o_busy(o_busy), .o_drop_pulse(o_drop_pulse), .o_proto_err(o_proto_err),
      .o_len_err(o_len_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   beat_t  pq[NP][$];
   obeat_t got[$];
   obeat_t exp_q[$];
   int     got_cyc[$];
   int     m_rr = 0;
   int     m_trunc = 0;
   int     n_pass = 0;
   int     n_tot = 0;
   int     n_drop = 0;
   int     n_proto = 0;
   int     n_len = 0;

   // Output monitor: every transferred beat plus pulse counts.
   always @(negedge clk) begin
      obeat_t ob;
      ob = {o_out_data, o_out_sop, o_out_eop, o_out_port};
      if (o_out_valid && out_ready) begin
         got.push_back(ob);
         got_cyc.push_back(cyc);
      end
      if (o_drop_pulse) n_drop++;
      if (o_proto_err)  n_proto++;
      if (o_len_err)    n_len++;
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      n_tot++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   function automatic bit pend();
      for (int p = 0; p < NP; p++) if (pq[p].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] cur_o();
      return {19'b0, o_out_valid, o_out_data, o_out_sop, o_out_eop, o_out_port};
   endfunction

   task automatic load_pkt(int p, logic [DW-1:0] base, int len, bit rnd);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.d   = rnd ? DW'($urandom) : base + DW'(k);
         b.sop = (k == 0);
         b.eop = (k == len - 1);
         pq[p].push_back(b);
      end
   endtask

   // Reference: whole packets in round-robin order from the ports with queued work;
   // with the length check, beats past MAX_LEN vanish and the MAX_LEN-th carries eop.
   task automatic model();
      beat_t  mq[NP][$];
      beat_t  b;
      obeat_t o;
      int     p;
      int     k;
      for (int i = 0; i < NP; i++) mq[i] = pq[i];
      m_trunc = 0;
      while (1) begin
         p = -1;
         for (int i = 0; i < NP; i++)
            if (p < 0 && mq[(m_rr + i) % NP].size() > 0) p = (m_rr + i) % NP;
         if (p < 0) break;
         k = 0;
         do begin
            b = mq[p].pop_front();
            k++;
            if (!LEN_ON || k <= ML) begin
               o = {b.d, b.sop, b.eop || (LEN_ON && k == ML), PW'(p)};
               exp_q.push_back(o);
            end
            if (LEN_ON && k == ML && !b.eop) m_trunc++;
         end while (!b.eop);
         m_rr = (p + 1) % NP;
      end
   endtask

   // Drive queued beats; rpct<0 selects the fixed ready pattern 1,0,0,1.
   task automatic run_drv(int vpct, int rpct, int ncyc);
      bit            prev_stall;
      logic [31:0]   prev_o;
      logic [NP-1:0] acc;
      int            iter;
      prev_stall = 1'b0;
      prev_o     = '0;
      iter       = 0;
      while ((ncyc > 0) ? (iter < ncyc) : (pend() && iter < 5000)) begin
         for (int p = 0; p < NP; p++) begin
            if (pq[p].size() > 0) begin
               in_valid[p]         = pq[p][0].sop || ($urandom_range(0, 99) < vpct);
               in_data[p*DW +: DW] = pq[p][0].d;
               in_sop[p]           = pq[p][0].sop;
               in_eop[p]           = pq[p][0].eop;
            end else begin
               in_valid[p] = 1'b0;
               in_sop[p]   = 1'b0;
               in_eop[p]   = 1'b0;
            end
         end
         out_ready = (rpct < 0) ? ((iter % 4 == 0) || (iter % 4 == 3))
                                : ($urandom_range(0, 99) < rpct);
         @(negedge clk);
         acc = in_valid & o_in_ready;
         if (prev_stall) chk("stall_hold", cur_o(), prev_o);
         if (o_out_valid && !out_ready) chk("stall_rdy", o_in_ready, 0);
         prev_stall = o_out_valid && !out_ready;
         prev_o     = cur_o();
         @(posedge clk); #1;
         for (int p = 0; p < NP; p++) if (acc[p]) void'(pq[p].pop_front());
         iter++;
      end
      if (ncyc == 0 && pend()) chk("timeout", pend(), 0);
      in_valid = '0;
      in_sop   = '0;
      in_eop   = '0;
   endtask

   task automatic flush();
      in_valid  = '0;
      in_sop    = '0;
      in_eop    = '0;
      out_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic cmp(string tag);
      chk({tag, "_n"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
      got.delete();
      got_cyc.delete();
      exp_q.delete();
   endtask

   initial begin
      int    t0;
      int    nd;
      int    npr;
      int    nl;
      beat_t b;

      // Reset state
      #2;
      chk("rst_valid",  o_out_valid, 0);
      chk("rst_out",    cur_o(), 0);
      chk("rst_busy",   o_busy, 0);
      chk("rst_ready",  o_in_ready, 0);
      chk("rst_pulses", {o_drop_pulse, o_proto_err, o_len_err}, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Simultaneous sop on ports 0 and 1, two rounds
      load_pkt(0, 8'h00, 4, 1'b0);
      load_pkt(1, 8'h10, 4, 1'b0);
      model();
      run_drv(100, 100, 0);
      flush();
      chk("rr_bubble", got_cyc[4] - got_cyc[3], 2);
      cmp("rr1");
      load_pkt(0, 8'h20, 4, 1'b0);
      load_pkt(1, 8'h30, 4, 1'b0);
      model();
      run_drv(100, 100, 0);
      flush();
      chk("rr2_first_port", got[0].port, 0);
      cmp("rr2");

      // Single port, latency and busy release
      load_pkt(0, 8'h00, 6, 1'b0);
      model();
      t0 = cyc;
      run_drv(100, 100, 0);
      chk("busy_after_eop", o_busy, 0);
      flush();
      chk("lat_first", got_cyc[0] - t0, 2);
      chk("lat_last", got_cyc[got_cyc.size() - 1] - t0, exp_q.size() + 1);
      cmp("single");

      // Backpressure 1,0,0,1
      load_pkt(2, 8'hA0, 4, 1'b0);
      model();
      run_drv(100, -1, 0);
      flush();
      cmp("bp");

      // Stray beat in IDLE
      nd = n_drop;
      in_valid = 3'b010;
      in_sop   = '0;
      in_data[DW +: DW] = 8'h55;
      @(negedge clk);
      chk("stray_rdy", o_in_ready, 3'b010);
      chk("stray_busy", o_busy, 0);
      @(posedge clk); #1;
      in_valid = '0;
      chk("stray_drop", o_drop_pulse, 1);
      chk("stray_nout", o_out_valid, 0);
      @(posedge clk); #1;
      chk("stray_drop_end", o_drop_pulse, 0);
      chk("stray_ndrop", n_drop - nd, 1);
      chk("stray_got", got.size(), 0);

      // Reset mid-packet after 3 of 6 beats
      load_pkt(0, 8'h30, 6, 1'b0);
      run_drv(100, 100, 4);
      chk("mrst_pre_busy", o_busy, 1);
      rst_n    = 1'b0;
      in_valid = '0;
      in_sop   = '0;
      in_eop   = '0;
      #1;
      chk("mrst_out", cur_o(), 0);
      chk("mrst_busy", o_busy, 0);
      chk("mrst_ready", o_in_ready, 0);
      chk("mrst_pulses", {o_drop_pulse, o_proto_err, o_len_err}, 0);
      for (int p = 0; p < NP; p++) pq[p].delete();
      got.delete();
      got_cyc.delete();
      m_rr = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      load_pkt(1, 8'h40, 3, 1'b0);
      model();
      run_drv(100, 100, 0);
      flush();
      cmp("post_rst");

      // sop repeated mid-packet
      npr = n_proto;
      b = {8'h70, 1'b1, 1'b0}; pq[2].push_back(b);
      b = {8'h71, 1'b0, 1'b0}; pq[2].push_back(b);
      b = {8'h72, 1'b1, 1'b0}; pq[2].push_back(b);
      b = {8'h73, 1'b0, 1'b1}; pq[2].push_back(b);
      model();
      run_drv(100, 100, 0);
      flush();
      chk("proto_cnt", n_proto - npr, 1);
      cmp("proto");

      // 7-beat packet: truncated to MAX_LEN when the length check is built in
      nl = n_len;
      load_pkt(0, 8'h10, 7, 1'b0);
      model();
      run_drv(100, 100, 0);
      flush();
      chk("len_cnt", n_len - nl, m_trunc);
      chk("len_idle", o_busy, 0);
      cmp("long");

      // Randomized packets on all ports with random gaps and backpressure
      for (int r = 0; r < 2; r++) begin
         nd  = n_drop;
         npr = n_proto;
         nl  = n_len;
         for (int p = 0; p < NP; p++)
            repeat (3) load_pkt(p, 8'h00, $urandom_range(1, 8), 1'b1);
         model();
         run_drv(70, 60, 0);
         flush();
         chk("rand_proto", n_proto - npr, 0);
         chk("rand_drop", n_drop - nd, 0);
         chk("rand_len", n_len - nl, m_trunc);
         cmp($sformatf("rand%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
